// File: rtl/rob_if.sv
// Dispatcher/CDB/commit bundle for reorder_buffer; master is the pipeline side, slave the ROB.
interface rob_if;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        issue_pred_taken;
  logic [4:0]  issue_tag;
  logic        rob_full;

  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_taken;

  logic [4:0]  query_tag1, query_tag2;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;

  logic        commit_valid;
  logic [4:0]  commit_rd, commit_tag;
  logic [31:0] commit_data;
  logic        store_commit;
  logic [4:0]  store_tag;
  logic        wrong_commit;
  logic [31:0] redirect_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pred_taken,
    output cdb_valid, cdb_tag, cdb_value, cdb_taken,
    output query_tag1, query_tag2,
    input  issue_tag, rob_full, query_ready1, query_ready2, query_value1, query_value2,
    input  commit_valid, commit_rd, commit_tag, commit_data,
    input  store_commit, store_tag, wrong_commit, redirect_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pred_taken,
    input  cdb_valid, cdb_tag, cdb_value, cdb_taken,
    input  query_tag1, query_tag2,
    output issue_tag, rob_full, query_ready1, query_ready2, query_value1, query_value2,
    output commit_valid, commit_rd, commit_tag, commit_data,
    output store_commit, store_tag, wrong_commit, redirect_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with CDB capture, operand query and branch-mispredict flush.
// Optional ROB_QUERY_BYPASS_EN: queries also see the same-cycle CDB broadcast.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16
) (
  input logic  clk,
  input logic  rst,
  input logic  rdy,
  rob_if.slave rob
);
  localparam int IW = $clog2(ROB_DEPTH);
  localparam logic [1:0] T_ALU = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2;

  logic [ROB_DEPTH-1:0]       busy, ready, pred, taken;
  logic [ROB_DEPTH-1:0][1:0]  etype;
  logic [ROB_DEPTH-1:0][4:0]  erd;
  logic [ROB_DEPTH-1:0][31:0] eval;
  logic [IW-1:0]              head, tail;
  logic [IW:0]                count;

  logic          flush, alloc, retire, cdb_hit, mispredict;
  logic [IW-1:0] cdb_idx;

  // Tag t names slot t-1; tag 0 and tags beyond the depth name nothing.
  function automatic logic tag_ok(input logic [4:0] t);
    return (t != 5'd0) && (t <= 5'(ROB_DEPTH));
  endfunction

  function automatic logic [IW-1:0] slot(input logic [4:0] t);
    return IW'(t - 5'd1);
  endfunction

  function automatic logic [32:0] lookup(input logic [4:0] t);
    logic [32:0] r;
    r = '0;
    if (t == 5'd0) r = {1'b1, 32'd0};
    else if (tag_ok(t) && busy[slot(t)] && ready[slot(t)]) r = {1'b1, eval[slot(t)]};
    return r;
  endfunction

  assign rob.rob_full  = (count == (IW+1)'(ROB_DEPTH));
  assign rob.issue_tag = 5'(tail) + 5'd1;

  // A pending mispredict freezes the buffer for exactly one edge, which then flushes it.
  assign flush      = rob.wrong_commit;
  assign alloc      = rdy && rob.issue_valid && !rob.rob_full && !flush;
  assign cdb_idx    = slot(rob.cdb_tag);
  assign cdb_hit    = rdy && !flush && rob.cdb_valid && tag_ok(rob.cdb_tag) && busy[cdb_idx];
  assign retire     = rdy && !flush && busy[head] && ready[head];
  assign mispredict = (etype[head] == T_BRANCH) && (taken[head] != pred[head]);

  always_comb begin
    {rob.query_ready1, rob.query_value1} = lookup(rob.query_tag1);
    {rob.query_ready2, rob.query_value2} = lookup(rob.query_tag2);
`ifdef ROB_QUERY_BYPASS_EN
    if (rob.query_tag1 != 5'd0 && rob.cdb_valid && rob.cdb_tag == rob.query_tag1)
      {rob.query_ready1, rob.query_value1} = {1'b1, rob.cdb_value};
    if (rob.query_tag2 != 5'd0 && rob.cdb_valid && rob.cdb_tag == rob.query_tag2)
      {rob.query_ready2, rob.query_value2} = {1'b1, rob.cdb_value};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= '0;
      ready            <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      rob.commit_valid <= 1'b0;
      rob.commit_rd    <= '0;
      rob.commit_tag   <= '0;
      rob.commit_data  <= '0;
      rob.store_commit <= 1'b0;
      rob.store_tag    <= '0;
      rob.wrong_commit <= 1'b0;
      rob.redirect_pc  <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (cdb_hit) begin
          ready[cdb_idx] <= 1'b1;
          eval[cdb_idx]  <= rob.cdb_value;
          taken[cdb_idx] <= rob.cdb_taken;
        end
        // head==tail only when empty (no retire) or full (no alloc), so these never collide.
        if (retire) begin
          busy[head] <= 1'b0;
          head       <= head + IW'(1);
        end
        if (alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          etype[tail] <= rob.issue_type;
          erd[tail]   <= rob.issue_rd;
          pred[tail]  <= rob.issue_pred_taken;
          tail        <= tail + IW'(1);
        end
        count <= count + (IW+1)'(alloc) - (IW+1)'(retire);
      end
      rob.commit_valid <= retire && etype[head] == T_ALU;
      rob.store_commit <= retire && etype[head] == T_STORE;
      rob.wrong_commit <= retire && mispredict;
      if (retire && etype[head] == T_ALU) begin
        rob.commit_rd   <= erd[head];
        rob.commit_tag  <= 5'(head) + 5'd1;
        rob.commit_data <= eval[head];
      end
      if (retire && etype[head] == T_STORE) rob.store_tag <= 5'(head) + 5'd1;
      if (retire && mispredict) rob.redirect_pc <= eval[head];
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed + random bench for reorder_buffer against a queue-based in-order retirement model.
module tb_reorder_buffer;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst, rdy;
  rob_if bus();

  reorder_buffer #(.ROB_DEPTH(D)) dut (.clk(clk), .rst(rst), .rdy(rdy), .rob(bus));

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          typ;
    logic [4:0]  rd;
    bit          pred;
    bit          done;
    logic [31:0] val;
    bit          tkn;
  } ent_t;

  ent_t        q[$];
  int          m_head;
  bit          m_valid = 1'b0;
  bit          e_cv, e_sc, e_wc;
  logic [4:0]  e_rd, e_ctag, e_stag;
  logic [31:0] e_cdata, e_rpc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_query(input logic [4:0] t, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    if (t == 5'd0) r = 1'b1;
    else foreach (q[i]) if (q[i].tag == int'(t) && q[i].done) begin r = 1'b1; v = q[i].val; end
`ifdef ROB_QUERY_BYPASS_EN
    if (t != 5'd0 && bus.cdb_valid && bus.cdb_tag == t) begin r = 1'b1; v = bus.cdb_value; end
`endif
  endtask

  task automatic check_comb();
    bit r;
    logic [31:0] v;
    if (!m_valid) return;
    chk("rob_full", 32'(bus.rob_full), 32'(q.size() == D));
    chk("issue_tag", 32'(bus.issue_tag), 32'((m_head + q.size()) % D + 1));
    model_query(bus.query_tag1, r, v);
    chk("query_ready1", 32'(bus.query_ready1), 32'(r));
    chk("query_value1", bus.query_value1, v);
    model_query(bus.query_tag2, r, v);
    chk("query_ready2", 32'(bus.query_ready2), 32'(r));
    chk("query_value2", bus.query_value2, v);
  endtask

  task automatic model_edge();
    bit ret, al;
    int ttag;
    ent_t h, n;
    if (rst) begin
      q.delete(); m_head = 0; m_valid = 1'b1;
      e_cv = 0; e_sc = 0; e_wc = 0; e_rd = 0; e_ctag = 0; e_stag = 0; e_cdata = 0; e_rpc = 0;
    end else if (rdy && m_valid) begin
      if (e_wc) begin
        q.delete(); m_head = 0; e_cv = 0; e_sc = 0; e_wc = 0;
      end else begin
        ret  = q.size() > 0 && q[0].done;
        al   = bus.issue_valid && q.size() < D;
        ttag = (m_head + q.size()) % D + 1;
        e_cv = 0; e_sc = 0; e_wc = 0;
        if (ret) begin
          h = q[0];
          if (h.typ == 0) begin e_cv = 1; e_rd = h.rd; e_ctag = 5'(h.tag); e_cdata = h.val; end
          else if (h.typ == 1) begin e_sc = 1; e_stag = 5'(h.tag); end
          else if (h.tkn != h.pred) begin e_wc = 1; e_rpc = h.val; end
        end
        if (bus.cdb_valid)
          foreach (q[i]) if (q[i].tag == int'(bus.cdb_tag)) begin
            q[i].done = 1; q[i].val = bus.cdb_value; q[i].tkn = bus.cdb_taken;
          end
        if (ret) begin void'(q.pop_front()); m_head = (m_head + 1) % D; end
        if (al) begin
          n.tag = ttag; n.typ = int'(bus.issue_type); n.rd = bus.issue_rd;
          n.pred = bus.issue_pred_taken; n.done = 0; n.val = 0; n.tkn = 0;
          q.push_back(n);
        end
      end
    end
  endtask

  task automatic check_regs();
    if (!m_valid) return;
    chk("commit_valid", 32'(bus.commit_valid), 32'(e_cv));
    chk("commit_rd", 32'(bus.commit_rd), 32'(e_rd));
    chk("commit_tag", 32'(bus.commit_tag), 32'(e_ctag));
    chk("commit_data", bus.commit_data, e_cdata);
    chk("store_commit", 32'(bus.store_commit), 32'(e_sc));
    chk("store_tag", 32'(bus.store_tag), 32'(e_stag));
    chk("wrong_commit", 32'(bus.wrong_commit), 32'(e_wc));
    chk("redirect_pc", bus.redirect_pc, e_rpc);
  endtask

  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_type = 0; bus.issue_rd = 0; bus.issue_pred_taken = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0; bus.cdb_taken = 0;
    bus.query_tag1 = 0; bus.query_tag2 = 0;
  endtask

  task automatic issue(input int typ, input int rd, input bit p);
    bus.issue_valid = 1; bus.issue_type = 2'(typ); bus.issue_rd = 5'(rd); bus.issue_pred_taken = p;
  endtask

  task automatic cdb(input int tag, input logic [31:0] v, input bit t);
    bus.cdb_valid = 1; bus.cdb_tag = 5'(tag); bus.cdb_value = v; bus.cdb_taken = t;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    rst = 1; rdy = 1; idle();
    cycle();
    // reset must win over rdy=0 and a pending issue
    rdy = 0; issue(0, 3, 0); cycle();
    rst = 0; rdy = 1; idle();
    chk("rst_full", 32'(bus.rob_full), 0);
    chk("rst_issue_tag", 32'(bus.issue_tag), 1);

    // single ALU round trip
    issue(0, 5, 0); cycle();
    idle(); cdb(1, 32'h1234, 0); cycle();
    idle(); cycle();
    chk("alu_cv", 32'(bus.commit_valid), 1);
    chk("alu_rd", 32'(bus.commit_rd), 5);
    chk("alu_tag", 32'(bus.commit_tag), 1);
    chk("alu_data", bus.commit_data, 32'h1234);
    cycle();
    chk("alu_pulse_end", 32'(bus.commit_valid), 0);

    // fill, blocked issue, wrap
    do_reset();
    for (int i = 0; i < D; i++) begin issue(0, i, 0); cycle(); end
    idle();
    chk("fill_full", 32'(bus.rob_full), 1);
    issue(0, 20, 0); cycle();
    chk("fill_17th_ignored", 32'(bus.rob_full), 1);
    cdb(1, 32'hAA, 0); cycle();
    bus.cdb_valid = 0; cycle();
    chk("wrap_tag", 32'(bus.issue_tag), 1);
    chk("wrap_not_full", 32'(bus.rob_full), 0);
    cycle();
    chk("wrap_full_again", 32'(bus.rob_full), 1);

    // out-of-order completion, in-order commit
    do_reset();
    issue(0, 1, 0); cycle();
    issue(0, 2, 0); cycle();
    idle(); cdb(2, 32'h22, 0); cycle();
    chk("ooo_no_commit", 32'(bus.commit_valid), 0);
    cdb(1, 32'h11, 0); cycle();
    idle(); cycle();
    chk("ooo_first_tag", 32'(bus.commit_tag), 1);
    cycle();
    chk("ooo_second_cv", 32'(bus.commit_valid), 1);
    chk("ooo_second_tag", 32'(bus.commit_tag), 2);

    // mispredict flush
    do_reset();
    issue(2, 0, 0); cycle();
    issue(0, 7, 0); cycle();
    idle(); cdb(1, 32'h80, 1); cycle();
    cdb(2, 32'h99, 0); cycle();
    chk("mis_wc", 32'(bus.wrong_commit), 1);
    chk("mis_pc", bus.redirect_pc, 32'h80);
    idle(); cycle();
    chk("mis_flush_tag", 32'(bus.issue_tag), 1);
    chk("mis_wc_end", 32'(bus.wrong_commit), 0);
    cycle();
    chk("mis_t2_gone", 32'(bus.commit_valid), 0);

    // query timing around a broadcast
    do_reset();
    for (int i = 0; i < 3; i++) begin issue(0, i + 1, 0); cycle(); end
    idle(); cdb(3, 32'd7, 0); bus.query_tag1 = 3; #1;
`ifdef ROB_QUERY_BYPASS_EN
    chk("qry_same_cycle", 32'(bus.query_ready1), 1);
`else
    chk("qry_same_cycle", 32'(bus.query_ready1), 0);
`endif
    cycle();
    idle(); bus.query_tag1 = 3; #1;
    chk("qry_next_ready", 32'(bus.query_ready1), 1);
    chk("qry_next_value", bus.query_value1, 32'd7);

    // rdy=0 stalls everything
    cdb(1, 32'h55, 0); cycle();
    rdy = 0; cdb(2, 32'h66, 0); cycle(); cycle();
    chk("stall_no_commit", 32'(bus.commit_valid), 0);
    rdy = 1; idle(); cycle();
    chk("stall_resume_cv", 32'(bus.commit_valid), 1);
    chk("stall_resume_tag", 32'(bus.commit_tag), 1);
    cycle();
    chk("stall_cdb_dropped", 32'(bus.commit_valid), 0);

    // random traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(99) == 0);
      rdy = ($urandom_range(9) != 0);
      bus.issue_valid = ($urandom_range(9) < 6);
      bus.issue_type = 2'($urandom_range(2));
      bus.issue_rd = 5'($urandom);
      bus.issue_pred_taken = 1'($urandom);
      bus.cdb_valid = ($urandom_range(9) < 6);
      if (q.size() > 0 && $urandom_range(9) < 8) bus.cdb_tag = 5'(q[$urandom_range(q.size() - 1)].tag);
      else bus.cdb_tag = 5'($urandom_range(31));
      bus.cdb_value = $urandom;
      bus.cdb_taken = 1'($urandom);
      if (q.size() > 0) bus.query_tag1 = 5'(q[$urandom_range(q.size() - 1)].tag);
      else bus.query_tag1 = 5'($urandom_range(31));
      bus.query_tag2 = 5'($urandom_range(31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
